// File: rtl/ram8_bist_pkg.sv
// Shared constants, FSM state type and pattern generator for the RAM8 self-test initiator.
package ram8_bist_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ERR_W  = 5;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StVerify,
        StWriteInv,
        StVerifyInv,
        StDone
    } state_e;

    // P(k) = seed + k (mod 2^16), optionally inverted.
    function automatic logic [WORD_W-1:0] pat(input logic [WORD_W-1:0] seed,
                                              input logic [ADDR_W-1:0] k,
                                              input logic              inv);
        logic [WORD_W-1:0] p;
        p = seed + WORD_W'(k);
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram8_bist.sv
// Four-phase write/verify self-test for the 8x16 RAM8: true pattern then inverted pattern,
// reporting pass/fail, mismatch count and first failing address.
module ram8_bist
    import ram8_bist_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] seed_i,
    output logic [WORD_W-1:0] mem_in_o,
    output logic              mem_load_o,
    output logic [ADDR_W-1:0] mem_address_o,
    input  logic [WORD_W-1:0] mem_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [WORD_W-1:0] seed_q, seed_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic              pass_q, pass_d;

    logic              inv;
    logic              last;
    logic [WORD_W-1:0] expected;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            k_q          <= '0;
            seed_q       <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            seed_q       <= seed_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            pass_q       <= pass_d;
        end
    end

    assign inv      = (state_q == StWriteInv) || (state_q == StVerifyInv);
    assign last     = (k_q == ADDR_W'(DEPTH - 1));
    assign expected = pat(seed_q, k_q, inv);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        seed_d        = seed_q;
        err_d         = err_q;
        fail_valid_d  = fail_valid_q;
        fail_addr_d   = fail_addr_q;
        pass_d        = pass_q;
        mem_in_o      = '0;
        mem_load_o    = 1'b0;
        mem_address_o = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StWrite;
                    k_d          = '0;
                    seed_d       = seed_i;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_addr_d  = '0;
                    pass_d       = 1'b0;
                end
            end
            StWrite, StWriteInv: begin
                busy_o        = 1'b1;
                mem_load_o    = 1'b1;
                mem_address_o = k_q;
                mem_in_o      = expected;
                k_d           = k_q + 1'b1;
                if (last) begin
                    state_d = (state_q == StWrite) ? StVerify : StVerifyInv;
                end
            end
            StVerify, StVerifyInv: begin
                busy_o        = 1'b1;
                mem_address_o = k_q;
                k_d           = k_q + 1'b1;
                if (mem_out_i != expected) begin
                    // At most 16 compares per run, so the 5-bit count cannot wrap.
                    err_d = err_q + ERR_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_addr_d  = k_q;
                    end
                end
                if (last) begin
                    state_d = (state_q == StVerify) ? StWriteInv : StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The verdict is already visible during the done cycle, then held from the register.
    assign pass_o       = (state_q == StDone) ? (err_q == '0) : pass_q;
    assign err_count_o  = err_q;
    assign fail_valid_o = fail_valid_q;
    assign fail_addr_o  = fail_addr_q;

endmodule

// File: tb/tb_ram8_bist.sv
// Randomised scoreboard bench for ram8_bist against a behavioural RAM8 with stuck-bit faults.
module tb_ram8_bist;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [15:0] seed_i;
    logic [15:0] mem_in_o;
    logic        mem_load_o;
    logic [2:0]  mem_address_o;
    logic [15:0] mem_out_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [4:0]  err_count_o;
    logic        fail_valid_o;
    logic [2:0]  fail_addr_o;

    ram8_bist dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .mem_in_o     (mem_in_o),
        .mem_load_o   (mem_load_o),
        .mem_address_o(mem_address_o),
        .mem_out_i    (mem_out_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .err_count_o  (err_count_o),
        .fail_valid_o (fail_valid_o),
        .fail_addr_o  (fail_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM8 responder with a fault-injecting read path.
    logic [15:0] mem [8];
    logic [15:0] st1 [8];
    logic [15:0] st0 [8];
    logic        read_zero;

    always @(posedge clk) begin
        if (mem_load_o) mem[mem_address_o] <= mem_in_o;
    end

    always_comb begin
        mem_out_i = read_zero ? 16'h0000 : ((mem[mem_address_o] | st1[mem_address_o])
                                            & ~st0[mem_address_o]);
    end

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [4:0] err;
        logic       fv;
        logic [2:0] fa;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    res_t last_res;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the run writes seed+k then ~(seed+k); each read sees the fault-mapped word.
    task automatic push_run(input logic [15:0] seed, input int n);
        res_t        r;
        wr_t         w;
        logic [15:0] p;
        logic [15:0] rd;
        int          errs;
        errs = 0;
        r.fv = 1'b0;
        r.fa = 3'd0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 8; k++) begin
                p = seed + 16'(k);
                if (ph == 1) p = ~p;
                w.cyc  = n + 1 + 16 * ph + k;
                w.addr = 3'(k);
                w.data = p;
                wr_q.push_back(w);
                rd = read_zero ? 16'h0000 : ((p | st1[k]) & ~st0[k]);
                if (rd != p) begin
                    errs++;
                    if (!r.fv) begin
                        r.fv = 1'b1;
                        r.fa = 3'(k);
                    end
                end
            end
        end
        r.cyc  = n + 33;
        r.err  = 5'(errs);
        r.pass = (errs == 0);
        res_q.push_back(r);
    endtask

    // Monitor: pops expected writes and results as the DUT presents them.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem_load_o) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_address_o), 32'hdead);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_cycle", 32'(cyc), 32'(w.cyc));
                    check("write_addr", 32'(mem_address_o), 32'(w.addr));
                    check("write_data", 32'(mem_in_o), 32'(w.data));
                    check("write_busy", 32'(busy_o), 32'd1);
                end
            end else begin
                check("idle_mem_in", 32'(mem_in_o), 32'd0);
            end
            if (!busy_o) check("idle_addr", 32'(mem_address_o), 32'd0);
            if (done_o) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    last_res = r;
                    check("done_cycle", 32'(cyc), 32'(r.cyc));
                    check("done_pass", 32'(pass_o), 32'(r.pass));
                    check("done_err", 32'(err_count_o), 32'(r.err));
                    check("done_fvalid", 32'(fail_valid_o), 32'(r.fv));
                    check("done_faddr", 32'(fail_addr_o), 32'(r.fa));
                    check("done_busy", 32'(busy_o), 32'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_in"}, 32'(mem_in_o), 32'd0);
        check({tag, "_load"}, 32'(mem_load_o), 32'd0);
        check({tag, "_addr"}, 32'(mem_address_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_pass"}, 32'(pass_o), 32'd0);
        check({tag, "_err"}, 32'(err_count_o), 32'd0);
        check({tag, "_fvalid"}, 32'(fail_valid_o), 32'd0);
        check({tag, "_faddr"}, 32'(fail_addr_o), 32'd0);
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 8; k++) begin
            st1[k] = 16'h0000;
            st0[k] = 16'h0000;
        end
        read_zero = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((res_q.size() != 0 || wr_q.size() != 0) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", 32'(res_q.size() + wr_q.size()), 32'd0);
        if (res_q.size() != 0 || wr_q.size() != 0) begin
            res_q.delete();
            wr_q.delete();
        end else begin
            check("held_pass", 32'(pass_o), 32'(last_res.pass));
            check("held_err", 32'(err_count_o), 32'(last_res.err));
            check("held_fvalid", 32'(fail_valid_o), 32'(last_res.fv));
            check("held_faddr", 32'(fail_addr_o), 32'(last_res.fa));
            check("held_busy", 32'(busy_o), 32'd0);
        end
    endtask

    task automatic start_run(input logic [15:0] s);
        @(posedge clk);
        #1;
        seed_i  = s;
        start_i = 1'b1;
        push_run(s, cyc);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seed_i  = 16'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int          n;
        logic [15:0] sa;
        logic [15:0] sb;
        rst_i   = 1'b1;
        start_i = 1'b0;
        seed_i  = 16'h0000;
        clear_faults();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_all_zero("post_reset");

        start_run(16'h0000);
        wait_drain(60);

        start_run(16'hFFFE);
        wait_drain(60);

        st1[5] = 16'h0001;
        start_run(16'h1234);
        wait_drain(60);
        check("stuck5_err", 32'(err_count_o), 32'd1);
        check("stuck5_addr", 32'(fail_addr_o), 32'd5);
        check("stuck5_pass", 32'(pass_o), 32'd0);
        clear_faults();

        read_zero = 1'b1;
        start_run(16'h0001);
        wait_drain(60);
        check("zero_err", 32'(err_count_o), 32'd16);
        check("zero_addr", 32'(fail_addr_o), 32'd0);
        clear_faults();

        // start_i held high across a run with a mid-run seed change.
        sa = 16'($urandom);
        sb = ~sa;
        @(posedge clk);
        #1;
        n       = cyc;
        seed_i  = sa;
        start_i = 1'b1;
        push_run(sa, n);
        while (cyc < n + 10) begin
            @(posedge clk);
            #1;
        end
        seed_i = sb;
        push_run(sb, n + 34);
        while (cyc < n + 35) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        wait_drain(80);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) begin
                st1[k] = ($urandom_range(0, 3) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0;
                st0[k] = ($urandom_range(0, 3) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0;
            end
            read_zero = ($urandom_range(0, 7) == 0);
            start_run(16'($urandom));
            wait_drain(60);
        end
        clear_faults();

        // Asynchronous reset in cycle 20 of a run.
        @(posedge clk);
        #1;
        n       = cyc;
        seed_i  = 16'($urandom);
        start_i = 1'b1;
        push_run(seed_i, n);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (cyc < n + 20) begin
            @(posedge clk);
            #1;
        end
        rst_i = 1'b1;
        #1;
        check_all_zero("abort");
        check("abort_writes_left", 32'(wr_q.size()), 32'd5);
        wr_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_all_zero("after_abort");

        start_run(16'($urandom));
        wait_drain(60);
        check("fresh_pass", 32'(pass_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
